// File: rtl/tx_port_arbiter.sv
// tx_port_arbiter: merges frames from a forwarder FIFO and a host FIFO onto one
// XGMII TX stream. Whole frames are granted round-robin, a fixed idle gap follows
// every terminate, and a frame whose source runs dry is aborted with an error word.
module tx_port_arbiter #(
  parameter int unsigned IFG_WORDS = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [71:0] fwd_dout,
  input  logic        fwd_empty,
  output logic        fwd_rd_en,
  input  logic [71:0] host_dout,
  input  logic        host_empty,
  output logic        host_rd_en,
  output logic [71:0] xgmii_tx,
  output logic [31:0] frame_cnt_fwd,
  output logic [31:0] frame_cnt_host,
  output logic [15:0] underrun_cnt
);

  localparam logic [71:0] IDLE_WORD = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] ERR_WORD  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};
  // The gap counter runs IFG_WORDS-1 down to 0; the last IFG cycle doubles as an
  // arbitration slot so back-to-back frames see exactly IFG_WORDS idles.
  localparam logic [3:0]  IFG_LOAD  = 4'(IFG_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TX    = 2'd1,
    ST_IFG   = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        sel_host_q, sel_host_d;   // source owning the current frame
  logic        last_host_q, last_host_d; // source granted most recently
  logic [3:0]  ifg_cnt_q, ifg_cnt_d;
  logic [71:0] xgmii_q, xgmii_d;
  logic [31:0] cnt_fwd_q, cnt_fwd_d;
  logic [31:0] cnt_host_q, cnt_host_d;
  logic [15:0] urun_q, urun_d;

  logic        fwd_start, host_start;
  logic        arb_slot, grant_valid, grant_host;
  logic [71:0] src_dout;
  logic        src_empty, src_term;
  logic        src_pop, fwd_drop, host_drop;

  function automatic logic is_start(input logic [71:0] w);
    return w[64] && (w[7:0] == 8'hFB);
  endfunction

  function automatic logic is_term(input logic [71:0] w);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (w[64+i] && (w[8*i +: 8] == 8'hFD)) hit = 1'b1;
    end
    return hit;
  endfunction

  // Source qualification, round-robin pick and granted-source mux
  always_comb begin
    fwd_start   = !fwd_empty && is_start(fwd_dout);
    host_start  = !host_empty && is_start(host_dout);
    arb_slot    = (state_q == ST_IDLE) || ((state_q == ST_IFG) && (ifg_cnt_q == 4'd0));
    grant_valid = arb_slot && (fwd_start || host_start);
    if (fwd_start && host_start) grant_host = !last_host_q;
    else                         grant_host = host_start;
    src_dout    = sel_host_q ? host_dout : fwd_dout;
    src_empty   = sel_host_q ? host_empty : fwd_empty;
    src_term    = is_term(src_dout);
  end

  // State register
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state and grant bookkeeping
  always_comb begin
    state_d     = state_q;
    sel_host_d  = sel_host_q;
    last_host_d = last_host_q;
    ifg_cnt_d   = ifg_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_valid) begin
          state_d     = ST_TX;
          sel_host_d  = grant_host;
          last_host_d = grant_host;
        end
      end
      ST_TX: begin
        if (src_empty) begin
          state_d = ST_DRAIN;
        end else if (src_term) begin
          state_d   = ST_IFG;
          ifg_cnt_d = IFG_LOAD;
        end
      end
      ST_DRAIN: begin
        if (!src_empty && src_term) begin
          state_d   = ST_IFG;
          ifg_cnt_d = IFG_LOAD;
        end
      end
      ST_IFG: begin
        if (ifg_cnt_q != 4'd0) begin
          ifg_cnt_d = ifg_cnt_q - 4'd1;
        end else if (grant_valid) begin
          state_d     = ST_TX;
          sel_host_d  = grant_host;
          last_host_d = grant_host;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output word, FIFO pops and counter updates
  always_comb begin
    xgmii_d    = IDLE_WORD;
    cnt_fwd_d  = cnt_fwd_q;
    cnt_host_d = cnt_host_q;
    urun_d     = urun_q;
    src_pop    = 1'b0;
    fwd_drop   = 1'b0;
    host_drop  = 1'b0;
    case (state_q)
      ST_TX: begin
        if (src_empty) begin
          xgmii_d = ERR_WORD;
          urun_d  = urun_q + 16'd1;
        end else begin
          xgmii_d = src_dout;
          src_pop = 1'b1;
          if (src_term) begin
            if (sel_host_q) cnt_host_d = cnt_host_q + 32'd1;
            else            cnt_fwd_d  = cnt_fwd_q + 32'd1;
          end
        end
      end
      ST_DRAIN: src_pop = !src_empty;
      default: ;
    endcase
    // Outside a frame, anything that is not a start word is stale and dropped
    if (arb_slot) begin
      fwd_drop  = !fwd_empty && !is_start(fwd_dout);
      host_drop = !host_empty && !is_start(host_dout);
    end
    fwd_rd_en  = sys_rst && (fwd_drop || (src_pop && !sel_host_q));
    host_rd_en = sys_rst && (host_drop || (src_pop && sel_host_q));
  end

  // Datapath and counter registers
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      sel_host_q  <= 1'b0;
      last_host_q <= 1'b1;
      ifg_cnt_q   <= 4'd0;
      xgmii_q     <= IDLE_WORD;
      cnt_fwd_q   <= 32'd0;
      cnt_host_q  <= 32'd0;
      urun_q      <= 16'd0;
    end else begin
      sel_host_q  <= sel_host_d;
      last_host_q <= last_host_d;
      ifg_cnt_q   <= ifg_cnt_d;
      xgmii_q     <= xgmii_d;
      cnt_fwd_q   <= cnt_fwd_d;
      cnt_host_q  <= cnt_host_d;
      urun_q      <= urun_d;
    end
  end

  assign xgmii_tx       = xgmii_q;
  assign frame_cnt_fwd  = cnt_fwd_q;
  assign frame_cnt_host = cnt_host_q;
  assign underrun_cnt   = urun_q;

endmodule

// File: tb/tb_tx_port_arbiter.sv
// Bench for tx_port_arbiter: directed frame scenarios on a default-gap instance,
// then random back-to-back frames on it and on a 5-word-gap instance, checked
// against a frame-level ordering model.
module tb_tx_port_arbiter;

  localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] ERR_W  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};

  logic        sys_clk;
  logic        sys_rst;
  logic [71:0] dout  [4];   // 0/1: fwd/host of u_dut0, 2/3: fwd/host of u_dut1
  logic        empty [4];
  logic        rd    [4];
  logic [71:0] xg    [2];
  logic [31:0] cf    [2];
  logic [31:0] ch    [2];
  logic [15:0] ur    [2];

  tx_port_arbiter u_dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .fwd_dout(dout[0]), .fwd_empty(empty[0]), .fwd_rd_en(rd[0]),
    .host_dout(dout[1]), .host_empty(empty[1]), .host_rd_en(rd[1]),
    .xgmii_tx(xg[0]), .frame_cnt_fwd(cf[0]), .frame_cnt_host(ch[0]),
    .underrun_cnt(ur[0])
  );

  tx_port_arbiter #(.IFG_WORDS(5)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .fwd_dout(dout[2]), .fwd_empty(empty[2]), .fwd_rd_en(rd[2]),
    .host_dout(dout[3]), .host_empty(empty[3]), .host_rd_en(rd[3]),
    .xgmii_tx(xg[1]), .frame_cnt_fwd(cf[1]), .frame_cnt_host(ch[1]),
    .underrun_cnt(ur[1])
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  int          total;
  int          bad;
  logic [71:0] fq  [4][$];  // FIFO contents
  bit          hold[4];     // forces a FIFO to look empty
  bit          pop [4];
  logic [71:0] obs [2];
  logic [71:0] oq  [2][$];  // captured output streams
  logic [71:0] ex  [$];     // directed expectation for u_dut0
  int          ecf, ech, eur;

  task automatic check(input string tag, input logic [71:0] got, input logic [71:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic refresh(input int k);
    empty[k] = (fq[k].size() == 0) || hold[k];
    if (fq[k].size() != 0) dout[k] = fq[k][0];
    else                   dout[k] = {8'($urandom), $urandom, $urandom};
  endtask

  task automatic push(input int k, input logic [71:0] w);
    fq[k].push_back(w);
    refresh(k);
  endtask

  // One clock: sample outputs and pops mid-cycle, then apply pops after the edge
  task automatic tick();
    @(negedge sys_clk);
    for (int k = 0; k < 4; k++) pop[k] = rd[k] && !empty[k];
    obs[0] = xg[0];
    obs[1] = xg[1];
    @(posedge sys_clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (pop[k]) void'(fq[k].pop_front());
      refresh(k);
    end
  endtask

  task automatic run_ex(input string tag);
    for (int i = 0; i < ex.size(); i++) begin
      tick();
      check($sformatf("%s[%0d]", tag, i), obs[0], ex[i]);
    end
    ex.delete();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) ex.push_back(IDLE_W);
  endtask

  task automatic check_cnt(input string tag, input int d);
    check({tag, "_fwd"},  72'(cf[d]), 72'(ecf));
    check({tag, "_host"}, 72'(ch[d]), 72'(ech));
    check({tag, "_urun"}, 72'(ur[d]), 72'(eur));
  endtask

  function automatic logic [71:0] w_start();
    logic [55:0] r;
    r = {24'($urandom), $urandom};
    return {8'h01, r, 8'hFB};
  endfunction

  function automatic logic [71:0] w_data();
    return {8'h00, $urandom, $urandom};
  endfunction

  function automatic logic [71:0] w_term(input int lane, input bit with_start);
    logic [71:0] w;
    w = {8'h00, $urandom, $urandom};
    for (int i = 0; i < 8; i++) begin
      if (i >= lane) begin
        w[64+i]    = 1'b1;
        w[8*i +: 8] = (i == lane) ? 8'hFD : 8'h07;
      end
    end
    if (with_start) begin
      w[64]   = 1'b1;
      w[7:0]  = 8'hFB;
    end
    return w;
  endfunction

  logic [71:0] a [3];
  logic [71:0] b [2];
  logic [71:0] u [7];
  logic [71:0] fw [$];
  logic [71:0] hw [$];
  logic [71:0] ew [$];
  int          fl [$];
  int          hl [$];
  int          el [$];
  int          nf, nh, fi, hi, fo, ho, len, p, e, g, extra, gap_want;
  bit          last_host, take_host;
  logic [71:0] w, got;

  initial begin
    total = 0;
    bad   = 0;
    sys_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      hold[k] = 1'b0;
      refresh(k);
    end
    repeat (3) tick();

    // Reset state, with a stale word at the fwd head that must not be popped
    push(0, w_data());
    #2;
    check("rst_rd_fwd", 72'(rd[0]), 72'(1'b0));
    ecf = 0; ech = 0; eur = 0;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_xgmii%0d", d), xg[d], IDLE_W);
      check_cnt($sformatf("rst_cnt%0d", d), d);
    end
    fq[0].delete();
    refresh(0);

    // Both FIFOs hold a frame at reset release: forwarder first, gap, then host
    a[0] = w_start(); a[1] = w_data(); a[2] = w_term(4, 1'b0);
    b[0] = w_start(); b[1] = w_term(7, 1'b0);
    for (int i = 0; i < 3; i++) push(0, a[i]);
    for (int i = 0; i < 2; i++) push(1, b[i]);
    tick();
    sys_rst = 1'b1;
    gap(2); ex.push_back(a[0]); ex.push_back(a[1]); ex.push_back(a[2]);
    gap(2); ex.push_back(b[0]); ex.push_back(b[1]); gap(2);
    run_ex("tie_release");
    ecf = 1; ech = 1;
    check_cnt("tie_release_cnt", 0);

    // Single 3-word forwarder frame, terminate in lane 4
    gap(2);
    run_ex("pre_single");
    a[0] = w_start(); a[1] = w_data(); a[2] = w_term(4, 1'b0);
    for (int i = 0; i < 3; i++) push(0, a[i]);
    gap(2); ex.push_back(a[0]); ex.push_back(a[1]); ex.push_back(a[2]); gap(2);
    run_ex("single");
    ecf = 2;
    check_cnt("single_cnt", 0);

    // Second tie: forwarder went last, so the host wins
    gap(1);
    run_ex("pre_tie2");
    a[0] = w_start(); a[1] = w_term(3, 1'b0);
    b[0] = w_start(); b[1] = w_term(1, 1'b0);
    for (int i = 0; i < 2; i++) push(0, a[i]);
    for (int i = 0; i < 2; i++) push(1, b[i]);
    gap(2); ex.push_back(b[0]); ex.push_back(b[1]);
    gap(2); ex.push_back(a[0]); ex.push_back(a[1]); gap(2);
    run_ex("tie2");
    ecf = 3; ech = 2;
    check_cnt("tie2_cnt", 0);

    // Underrun after 2 of 5 words, followed by a clean frame in the same FIFO
    gap(1);
    run_ex("pre_urun");
    u[0] = w_start(); u[1] = w_data(); u[2] = w_data(); u[3] = w_data();
    u[4] = w_term(2, 1'b0); u[5] = w_start(); u[6] = w_term(5, 1'b0);
    for (int i = 0; i < 7; i++) push(0, u[i]);
    for (int i = 0; i < 15; i++) begin
      if (i == 3) begin hold[0] = 1'b1; refresh(0); end
      if (i == 6) begin hold[0] = 1'b0; refresh(0); end
      tick();
      case (i)
        2:       w = u[0];
        3:       w = u[1];
        4:       w = ERR_W;
        12:      w = u[5];
        13:      w = u[6];
        default: w = IDLE_W;
      endcase
      check($sformatf("urun[%0d]", i), obs[0], w);
      if (i == 11) check("urun_no_count", 72'(cf[0]), 72'(ecf));
    end
    ecf = 4; eur = 1;
    check_cnt("urun_cnt", 0);
    check("urun_fifo_drained", 72'(fq[0].size()), 72'(0));

    // Two garbage words ahead of a host start are dropped with idle output
    gap(2);
    run_ex("pre_garbage");
    u[0] = w_data(); u[1] = w_data(); u[2] = w_start(); u[3] = w_data();
    u[4] = w_term(6, 1'b0);
    for (int i = 0; i < 5; i++) push(1, u[i]);
    gap(4); ex.push_back(u[2]); ex.push_back(u[3]); ex.push_back(u[4]); gap(1);
    run_ex("garbage");
    ech = 3;
    check_cnt("garbage_cnt", 0);
    check("garbage_fifo_empty", 72'(fq[1].size()), 72'(0));

    // Asynchronous reset in the middle of a frame
    gap(2);
    run_ex("pre_midrst");
    u[0] = w_start(); u[1] = w_data(); u[2] = w_data(); u[3] = w_data();
    u[4] = w_data(); u[5] = w_term(0, 1'b0);
    for (int i = 0; i < 6; i++) push(0, u[i]);
    gap(2); ex.push_back(u[0]); ex.push_back(u[1]);
    run_ex("midrst_pre");
    #2;
    sys_rst = 1'b0;
    #1;
    check("midrst_async_idle", xg[0], IDLE_W);
    check("midrst_rd_fwd", 72'(rd[0]), 72'(1'b0));
    ecf = 0; ech = 0; eur = 0;
    check_cnt("midrst_cnt", 0);
    tick();
    check("midrst_fifo_left", 72'(fq[0].size()), 72'(3));
    a[0] = w_start(); a[1] = w_term(1, 1'b0);
    push(0, a[0]); push(0, a[1]);
    sys_rst = 1'b1;
    gap(5); ex.push_back(a[0]); ex.push_back(a[1]); gap(2);
    run_ex("after_rst");
    ecf = 1;
    check_cnt("after_rst_cnt", 0);

    // Random back-to-back frames on both instances (gap 2 and gap 5)
    sys_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      fq[k].delete();
      refresh(k);
    end
    tick();
    nf = int'($urandom_range(3, 6));
    nh = int'($urandom_range(3, 6));
    for (int s = 0; s < 2; s++) begin
      for (int f = 0; f < ((s == 0) ? nf : nh); f++) begin
        len = int'($urandom_range(1, 6));
        for (int j = 0; j < len; j++) begin
          if (len == 1)           w = w_term(int'($urandom_range(1, 7)), 1'b1);
          else if (j == 0)        w = w_start();
          else if (j == len - 1)  w = w_term(int'($urandom_range(0, 7)), 1'b0);
          else if ($urandom_range(0, 3) == 0) w = w_start();
          else                    w = w_data();
          push(s, w);
          push(s + 2, w);
          if (s == 0) fw.push_back(w);
          else        hw.push_back(w);
        end
        if (s == 0) fl.push_back(len);
        else        hl.push_back(len);
      end
    end
    sys_rst = 1'b1;

    // Frame-level order: alternate on ties starting with the forwarder
    fi = 0; hi = 0; fo = 0; ho = 0; last_host = 1'b1;
    while (fi < nf || hi < nh) begin
      if (fi < nf && hi < nh) take_host = !last_host;
      else                    take_host = (hi < nh);
      if (take_host) begin
        for (int j = 0; j < hl[hi]; j++) ew.push_back(hw[ho + j]);
        el.push_back(hl[hi]);
        ho += hl[hi];
        hi++;
      end else begin
        for (int j = 0; j < fl[fi]; j++) ew.push_back(fw[fo + j]);
        el.push_back(fl[fi]);
        fo += fl[fi];
        fi++;
      end
      last_host = take_host;
    end

    for (int c = 0; c < 300; c++) begin
      tick();
      oq[0].push_back(obs[0]);
      oq[1].push_back(obs[1]);
    end

    for (int d = 0; d < 2; d++) begin
      gap_want = (d == 0) ? 2 : 5;
      p = 0;
      e = 0;
      while (p < oq[d].size() && oq[d][p] === IDLE_W) p++;
      for (int f = 0; f < el.size(); f++) begin
        for (int j = 0; j < el[f]; j++) begin
          if (p < oq[d].size()) got = oq[d][p];
          else                  got = 'x;
          check($sformatf("rnd%0d_f%0d_w%0d", d, f, j), got, ew[e]);
          p++;
          e++;
        end
        if (f != el.size() - 1) begin
          g = 0;
          while (p < oq[d].size() && oq[d][p] === IDLE_W) begin
            g++;
            p++;
          end
          check($sformatf("rnd%0d_gap%0d", d, f), 72'(g), 72'(gap_want));
        end
      end
      extra = 0;
      while (p < oq[d].size()) begin
        if (oq[d][p] !== IDLE_W) extra++;
        p++;
      end
      check($sformatf("rnd%0d_trailing", d), 72'(extra), 72'(0));
      ecf = nf; ech = nh; eur = 0;
      check_cnt($sformatf("rnd%0d_cnt", d), d);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_port_arbiter.md
TX_PORT_ARBITER -- requirements
Module: tx_port_arbiter

Interface
REQ-001 SHALL have parameter IFG_WORDS, default 2, meaning the minimum number of idle XGMII words inserted after each terminate word (legal range 1-15).
REQ-002 SHALL have port sys_clk  input  1  the single clock; all logic is rising-edge.
REQ-003 SHALL have port sys_rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port fwd_dout  input  72  head word of the forwarder-side FWFT FIFO; format {ctrl[7:0], data[63:0]}, lane 0 = bits [7:0] / ctrl[0].
REQ-005 SHALL have port fwd_empty  input  1  the forwarder FIFO is empty.
REQ-006 SHALL have port fwd_rd_en  output  1  pops the forwarder FIFO.
REQ-007 SHALL have port host_dout  input  72  head word of the host/NIC FWFT FIFO, same format.
REQ-008 SHALL have port host_empty  input  1  the host FIFO is empty.
REQ-009 SHALL have port host_rd_en  output  1  pops the host FIFO.
REQ-010 SHALL have port xgmii_tx  output  72  registered XGMII TX word, {txc[7:0], txd[63:0]}.
REQ-011 SHALL have port frame_cnt_fwd  output  32  count of frames completed from the forwarder FIFO.
REQ-012 SHALL have port frame_cnt_host  output  32  count of frames completed from the host FIFO.
REQ-013 SHALL have port underrun_cnt  output  16  count of frames aborted by underrun.

Function
REQ-014 SHALL define the idle word as ctrl=8'hFF, data=64'h0707070707070707.
REQ-015 SHALL define the start word as ctrl[0]=1 and data[7:0]=8'hFB.
REQ-016 SHALL define a terminate word as any lane i with ctrl[i]=1 and data byte i=8'hFD.
REQ-017 SHALL define the error word as ctrl=8'hFF, data=64'hFEFEFEFEFEFEFEFE.
REQ-018 SHALL implement the states IDLE, TX, IFG and DRAIN.
REQ-019 SHALL, in IDLE, select a non-empty source whose head is a start word; when both qualify it SHALL grant round-robin, with the source not granted last winning, and after reset the forwarder SHALL win the first tie.
REQ-020 SHALL, in IDLE, pop and discard a head word that is not a start word (one word per cycle per source, both sources in parallel), while emitting idle and not counting the word.
REQ-021 SHALL assert rd_en only for the granted source in TX, combinationally as state==TX & !empty; a word is consumed on a cycle with rd_en=1 and empty=0.
REQ-022 SHALL register each consumed word onto xgmii_tx one cycle after consumption (latency 1), and the start word SHALL appear on xgmii_tx exactly 2 cycles after the grant cycle.
REQ-023 SHALL, on the cycle IDLE grants, move to TX and drive idle.
REQ-024 SHALL, in TX, move to IFG when the word consumed is a terminate word, and increment the matching frame counter by 1 on that cycle.
REQ-025 SHALL treat the granted source going empty in TX as an underrun: it SHALL drive the error word for that cycle, increment underrun_cnt, and move to DRAIN.
REQ-026 SHALL, in DRAIN, pop the granted source whenever it is non-empty, discarding words and driving idle, until a terminate word is popped, then move to IFG.
REQ-027 SHALL, in IFG, drive exactly IFG_WORDS idle words, counted by a 4-bit counter, then move to IDLE.
REQ-028 SHALL drive idle on xgmii_tx in every cycle that does not carry a consumed frame word or an error word.
REQ-029 SHALL let all counters wrap modulo 2^width, with no saturation.
REQ-030 SHALL handle a start word seen in TX as data with no special action, so that only terminate ends a frame.
REQ-031 SHALL, when a single word is both start and terminate, transmit it and move directly to IFG, counting the frame.

Reset
REQ-032 SHALL, while sys_rst=0, force xgmii_tx to idle, both rd_en outputs to 0, all counters to 0, state to IDLE, and the round-robin pointer to favour the forwarder, asynchronously.
REQ-033 SHALL abandon a frame cut by reset mid-frame with no terminate emitted, and the first frame after release SHALL be accepted only from a start word.

Verification
REQ-034 SHALL be verified by this scenario: fwd FIFO holds a 3-word frame (start, data, terminate in lane 4), host empty -> xgmii_tx shows idle, then the 3 words on consecutive cycles from 2 cycles after grant, then 2 idles; frame_cnt_fwd=1.
REQ-035 SHALL be verified by this scenario: both FIFOs hold one frame each at reset release -> the forwarder frame goes first, then 2 idles, then the host frame; both counters read 1.
REQ-036 SHALL be verified by this scenario: fwd_empty goes to 1 after 2 of 5 words -> one error word is emitted, underrun_cnt=1, the remaining words are discarded through terminate, then 2 idles, and frame_cnt_fwd stays 0.
REQ-037 SHALL be verified by this scenario: the host FIFO head holds 2 garbage words before a start -> both are popped with idle output, then the frame transmits normally.
REQ-038 SHALL be verified by this scenario: sys_rst driven low mid-frame -> xgmii_tx is idle immediately (asynchronously), counters read 0, and the next complete frame transmits correctly.
REQ-039 SHALL be verified by this scenario: IFG_WORDS=5 with back-to-back frames from both FIFOs -> exactly 5 idles appear between the terminate word and the next start word.
